// File: rtl/sd_req_arbiter_if.sv
// Bundle of the two requester ports and the mist_io SD sector channel seen by sd_req_arbiter.
// master is the arbiter's view, slave is the environment (requesters plus mist_io).
interface sd_req_arbiter_if;
    logic        rd_0;
    logic        wr_0;
    logic        rd_1;
    logic        wr_1;
    logic [31:0] lba_0;
    logic [31:0] lba_1;
    logic [7:0]  buff_din_0;
    logic [7:0]  buff_din_1;
    logic        done_0;
    logic        done_1;
    logic        err_0;
    logic        err_1;
    logic        grant_0;
    logic        grant_1;
    logic        buff_wr_0;
    logic        buff_wr_1;
    logic [8:0]  buff_addr;
    logic [7:0]  buff_dout;
    logic        sd_rd;
    logic        sd_wr;
    logic [31:0] sd_lba;
    logic        sd_ack;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic        sd_buff_wr;
    logic [7:0]  sd_buff_din;

    modport master (
        input  rd_0, wr_0, rd_1, wr_1, lba_0, lba_1, buff_din_0, buff_din_1,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        output done_0, done_1, err_0, err_1, grant_0, grant_1,
        output buff_wr_0, buff_wr_1, buff_addr, buff_dout,
        output sd_rd, sd_wr, sd_lba, sd_buff_din
    );

    modport slave (
        output rd_0, wr_0, rd_1, wr_1, lba_0, lba_1, buff_din_0, buff_din_1,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
        input  done_0, done_1, err_0, err_1, grant_0, grant_1,
        input  buff_wr_0, buff_wr_1, buff_addr, buff_dout,
        input  sd_rd, sd_wr, sd_lba, sd_buff_din
    );
endinterface

// File: rtl/sd_req_arbiter.sv
// Two-port round-robin scheduler for the mist_io SD sector channel; routes the byte stream to the granted port.
// Optional no-ack abort is enabled by defining SDARB_TIMEOUT_EN.
module sd_req_arbiter #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_000_000
) (
    input  logic             clk_sys,
    input  logic             reset,
    sd_req_arbiter_if.master bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] XFER  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state_reg;
    logic        last_reg;
    logic [1:0]  grant_reg;
    logic [1:0]  done_reg;
    logic        sd_rd_reg;
    logic        sd_wr_reg;
    logic [31:0] sd_lba_reg;

    logic [1:0]  req;
    logic        sel_port;
    logic        sel_rd;
    logic        sel_wr;
    logic [31:0] sel_lba;

    assign req = {bus.rd_1 | bus.wr_1, bus.rd_0 | bus.wr_0};

    // On a tie the port that did not win last time goes next.
    always_comb begin
        sel_port = req[1] & (~req[0] | ~last_reg);
        sel_rd   = sel_port ? bus.rd_1  : bus.rd_0;
        sel_wr   = sel_port ? bus.wr_1  : bus.wr_0;
        sel_lba  = sel_port ? bus.lba_1 : bus.lba_0;
    end

`ifdef SDARB_TIMEOUT_EN
    logic [23:0] cnt_reg;
    logic        timed_out_reg;
    logic [1:0]  err_reg;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            last_reg   <= 1'b1;
            grant_reg  <= 2'b00;
            done_reg   <= 2'b00;
            sd_rd_reg  <= 1'b0;
            sd_wr_reg  <= 1'b0;
            sd_lba_reg <= 32'd0;
`ifdef SDARB_TIMEOUT_EN
            cnt_reg       <= 24'd0;
            timed_out_reg <= 1'b0;
            err_reg       <= 2'b00;
`endif
        end else begin
            done_reg <= 2'b00;
`ifdef SDARB_TIMEOUT_EN
            err_reg  <= 2'b00;
`endif
            case (state_reg)
                IDLE: begin
                    if (req != 2'b00) begin
                        sd_lba_reg <= sel_lba;
                        sd_rd_reg  <= sel_rd;
                        sd_wr_reg  <= sel_wr & ~sel_rd;
                        grant_reg  <= sel_port ? 2'b10 : 2'b01;
                        last_reg   <= sel_port;
                        state_reg  <= ISSUE;
`ifdef SDARB_TIMEOUT_EN
                        cnt_reg    <= 24'd0;
`endif
                    end
                end
                ISSUE: begin
                    if (bus.sd_ack) begin
                        sd_rd_reg <= 1'b0;
                        sd_wr_reg <= 1'b0;
                        state_reg <= XFER;
`ifdef SDARB_TIMEOUT_EN
                    end else if (cnt_reg == TIMEOUT_CYCLES - 24'd1) begin
                        sd_rd_reg     <= 1'b0;
                        sd_wr_reg     <= 1'b0;
                        timed_out_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 24'd1;
`endif
                    end
                end
                XFER: begin
                    if (!bus.sd_ack) begin
                        state_reg <= DONE;
                    end
                end
                default: begin
                    done_reg  <= grant_reg;
                    grant_reg <= 2'b00;
                    state_reg <= IDLE;
`ifdef SDARB_TIMEOUT_EN
                    err_reg       <= timed_out_reg ? grant_reg : 2'b00;
                    timed_out_reg <= 1'b0;
`endif
                end
            endcase
        end
    end

`ifdef SDARB_TIMEOUT_EN
    assign bus.err_0 = err_reg[0];
    assign bus.err_1 = err_reg[1];
`else
    assign bus.err_0 = 1'b0;
    assign bus.err_1 = 1'b0;
    // Parameter kept in the list so both builds instantiate identically.
    if (TIMEOUT_CYCLES == 24'd0) begin : g_timeout_unused
    end
`endif

    assign bus.sd_rd   = sd_rd_reg;
    assign bus.sd_wr   = sd_wr_reg;
    assign bus.sd_lba  = sd_lba_reg;
    assign bus.grant_0 = grant_reg[0];
    assign bus.grant_1 = grant_reg[1];
    assign bus.done_0  = done_reg[0];
    assign bus.done_1  = done_reg[1];

    // Byte stream routing is combinational; an ungranted port never sees a write strobe.
    assign bus.buff_wr_0   = bus.sd_buff_wr & grant_reg[0];
    assign bus.buff_wr_1   = bus.sd_buff_wr & grant_reg[1];
    assign bus.buff_addr   = bus.sd_buff_addr;
    assign bus.buff_dout   = bus.sd_buff_dout;
    assign bus.sd_buff_din = grant_reg[0] ? bus.buff_din_0 :
                             grant_reg[1] ? bus.buff_din_1 : 8'h00;
endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed bench for sd_req_arbiter: one line per transaction, one summary line at the end.
module tb_sd_req_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    sd_req_arbiter_if bus();

    sd_req_arbiter #(.TIMEOUT_CYCLES(24'd16)) dut (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.rd_0 = 0; bus.wr_0 = 0; bus.rd_1 = 0; bus.wr_1 = 0;
        bus.lba_0 = 32'd0; bus.lba_1 = 32'd0;
        bus.buff_din_0 = 8'h00; bus.buff_din_1 = 8'h00;
        bus.sd_ack = 0; bus.sd_buff_addr = 9'd0; bus.sd_buff_dout = 8'h00; bus.sd_buff_wr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        check("rst_sd_rd", {31'd0, bus.sd_rd}, 0);
        check("rst_sd_wr", {31'd0, bus.sd_wr}, 0);
        check("rst_sd_lba", bus.sd_lba, 0);
        check("rst_grant", {30'd0, bus.grant_1, bus.grant_0}, 0);
        check("rst_done", {30'd0, bus.done_1, bus.done_0}, 0);
        check("rst_err", {30'd0, bus.err_1, bus.err_0}, 0);
        rst = 1'b0;
    endtask

    // Request(s) already driven; grant is expected at the very next edge.
    task automatic serve(input int p, input bit exp_rd, input logic [31:0] exp_lba,
                         input logic [7:0] exp_din, input int nbytes);
        int n_mine = 0;
        int n_other = 0;
        logic g_mine, g_other, w_mine, w_other, d_mine, d_other, e_mine;
        tick();
        g_mine  = (p == 0) ? bus.grant_0 : bus.grant_1;
        g_other = (p == 0) ? bus.grant_1 : bus.grant_0;
        check("grant_mine", {31'd0, g_mine}, 1);
        check("grant_other", {31'd0, g_other}, 0);
        check("sd_rd", {31'd0, bus.sd_rd}, {31'd0, exp_rd});
        check("sd_wr", {31'd0, bus.sd_wr}, {31'd0, ~exp_rd});
        check("sd_lba", bus.sd_lba, exp_lba);
        bus.sd_ack = 1'b1;
        tick();
        check("rdwr_after_ack", {30'd0, bus.sd_rd, bus.sd_wr}, 0);
        for (int i = 0; i < nbytes; i++) begin
            bus.sd_buff_wr   = 1'b1;
            bus.sd_buff_addr = i[8:0];
            bus.sd_buff_dout = i[7:0] ^ 8'h5A;
            #1;
            w_mine  = (p == 0) ? bus.buff_wr_0 : bus.buff_wr_1;
            w_other = (p == 0) ? bus.buff_wr_1 : bus.buff_wr_0;
            n_mine  += int'(w_mine);
            n_other += int'(w_other);
            if (i == 1) begin
                check("buff_addr", {23'd0, bus.buff_addr}, 32'd1);
                check("buff_dout", {24'd0, bus.buff_dout}, 32'h5B);
                check("sd_buff_din", {24'd0, bus.sd_buff_din}, {24'd0, exp_din});
            end
            @(negedge clk);
        end
        bus.sd_buff_wr = 1'b0;
        check("strobes_mine", n_mine, nbytes);
        check("strobes_other", n_other, 0);
        bus.sd_ack = 1'b0;
        tick();
        check("done_early", {30'd0, bus.done_1, bus.done_0}, 0);
        tick();
        d_mine  = (p == 0) ? bus.done_0 : bus.done_1;
        d_other = (p == 0) ? bus.done_1 : bus.done_0;
        e_mine  = (p == 0) ? bus.err_0 : bus.err_1;
        check("done_mine", {31'd0, d_mine}, 1);
        check("done_other", {31'd0, d_other}, 0);
        check("err_mine", {31'd0, e_mine}, 0);
        check("grant_cleared", {30'd0, bus.grant_1, bus.grant_0}, 0);
        $display("xfer port=%0d rd=%0d lba=%08h bytes=%0d errors=%0d", p, exp_rd, exp_lba, nbytes, n_errors);
    endtask

    initial begin
        clear_inputs();

        // Single read on port 0 with a full sector.
        do_reset();
        bus.rd_0 = 1; bus.lba_0 = 32'h0000_1234; bus.buff_din_0 = 8'h3C; bus.buff_din_1 = 8'hC3;
        serve(0, 1'b1, 32'h0000_1234, 8'h3C, 512);
        bus.rd_0 = 0;
        tick();
        check("no_second_done", {30'd0, bus.done_1, bus.done_0}, 0);

        // rd_0 and wr_1 together from reset: port 0 then port 1.
        do_reset();
        bus.rd_0 = 1; bus.lba_0 = 32'hAAAA_0001; bus.buff_din_0 = 8'h11;
        bus.wr_1 = 1; bus.lba_1 = 32'h5555_0002; bus.buff_din_1 = 8'hA5;
        serve(0, 1'b1, 32'hAAAA_0001, 8'h11, 4);
        bus.rd_0 = 0;
        serve(1, 1'b0, 32'h5555_0002, 8'hA5, 4);
        bus.wr_1 = 0;

        // Both ports requesting continuously alternate.
        do_reset();
        bus.rd_0 = 1; bus.lba_0 = 32'h0000_00A0; bus.buff_din_0 = 8'h0A;
        bus.rd_1 = 1; bus.lba_1 = 32'h0000_00B1; bus.buff_din_1 = 8'h0B;
        serve(0, 1'b1, 32'h0000_00A0, 8'h0A, 2);
        serve(1, 1'b1, 32'h0000_00B1, 8'h0B, 2);
        serve(0, 1'b1, 32'h0000_00A0, 8'h0A, 2);
        serve(1, 1'b1, 32'h0000_00B1, 8'h0B, 2);
        bus.rd_0 = 0; bus.rd_1 = 0;

        // rd and wr both set on one port: read wins.
        do_reset();
        bus.rd_0 = 1; bus.wr_0 = 1; bus.lba_0 = 32'h0000_0777; bus.buff_din_0 = 8'h77;
        serve(0, 1'b1, 32'h0000_0777, 8'h77, 2);
        bus.rd_0 = 0; bus.wr_0 = 0;

        // Stale ack in IDLE is ignored.
        do_reset();
        bus.sd_ack = 1;
        tick();
        check("stale_ack_grant", {30'd0, bus.grant_1, bus.grant_0}, 0);
        check("stale_ack_rd", {31'd0, bus.sd_rd}, 0);
        bus.sd_ack = 0;
        tick();
        $display("stale ack in idle errors=%0d", n_errors);

`ifdef SDARB_TIMEOUT_EN
        // No ack on port 1: abort after 16 ISSUE cycles, then port 0 works.
        do_reset();
        bus.rd_1 = 1; bus.lba_1 = 32'h0000_0DEA;
        tick();
        check("to_grant", {31'd0, bus.grant_1}, 1);
        for (int k = 1; k <= 15; k++) begin
            tick();
            check("to_wait_rd", {31'd0, bus.sd_rd}, 1);
        end
        tick();
        check("to_rd_drop", {31'd0, bus.sd_rd}, 0);
        check("to_no_done_yet", {31'd0, bus.done_1}, 0);
        tick();
        check("to_done_1", {31'd0, bus.done_1}, 1);
        check("to_err_1", {31'd0, bus.err_1}, 1);
        check("to_err_0", {31'd0, bus.err_0}, 0);
        bus.rd_1 = 0;
        $display("timeout abort port=1 errors=%0d", n_errors);
        bus.rd_0 = 1; bus.lba_0 = 32'h0000_0F00; bus.buff_din_0 = 8'h44;
        serve(0, 1'b1, 32'h0000_0F00, 8'h44, 2);
        bus.rd_0 = 0;
`endif

        // Reset in the middle of XFER: everything drops at once, no done.
        do_reset();
        bus.rd_0 = 1; bus.lba_0 = 32'h0000_0099;
        tick();
        bus.sd_ack = 1;
        tick();
        bus.sd_buff_wr = 1;
        #1;
        check("pre_rst_buff_wr_0", {31'd0, bus.buff_wr_0}, 1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_rd", {31'd0, bus.sd_rd}, 0);
        check("mid_rst_grant", {30'd0, bus.grant_1, bus.grant_0}, 0);
        check("mid_rst_buff_wr", {30'd0, bus.buff_wr_1, bus.buff_wr_0}, 0);
        check("mid_rst_lba", bus.sd_lba, 0);
        bus.rd_0 = 0; bus.rd_1 = 1; bus.lba_1 = 32'h0000_BEEF; bus.buff_din_1 = 8'hEE;
        @(negedge clk);
        check("mid_rst_done", {30'd0, bus.done_1, bus.done_0}, 0);
        rst = 1'b0;
        bus.sd_ack = 0; bus.sd_buff_wr = 0;
        $display("reset during xfer errors=%0d", n_errors);
        serve(1, 1'b1, 32'h0000_BEEF, 8'hEE, 2);
        bus.rd_1 = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sd_req_arbiter.md
# sd_req_arbiter

Two-port scheduler for the single mist_io SD sector channel (sd_rd / sd_wr / sd_lba / sd_ack / sd_buff_*). It sits between mist_io and two requesters: the sd_card SPI emulation used by the MSX core (port 0) and a future image/ROM loader (port 1). It grants one sector transaction at a time, round-robin on contention, and routes the sector-buffer byte stream to the granted port only. Optionally, it aborts a transaction that mist_io never acknowledges.

## Interface
Parameters:
- TIMEOUT_CYCLES, 24'd4_000_000, cycles from issue to sd_ack rise before abort; only used with SDARB_TIMEOUT_EN.

Ports:
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_0, wr_0 / rd_1, wr_1  in  1 each  level requests; held until the matching done pulse.
- lba_0 / lba_1  in  32  sector address; stable while request high.
- buff_din_0 / buff_din_1  in  8  write-data byte from the requester for the current sd_buff_addr.
- done_0 / done_1  out  1  one-cycle completion pulse.
- err_0 / err_1  out  1  one-cycle pulse coincident with done on timeout abort.
- grant_0 / grant_1  out  1  port owns the channel; one-hot or zero.
- buff_wr_0 / buff_wr_1  out  1  sd_buff_wr gated by grant.
- buff_addr  out  9  sd_buff_addr passthrough, shared.
- buff_dout  out  8  sd_buff_dout passthrough, shared.
- sd_rd, sd_wr  out  1  to mist_io.
- sd_lba  out  32  to mist_io; registered.
- sd_ack  in  1  from mist_io.
- sd_buff_addr  in  9; sd_buff_dout  in  8; sd_buff_wr  in  1  from mist_io.
- sd_buff_din  out  8  to mist_io; buff_din of the granted port, 8'h00 if none.

## Operation
- States: IDLE, ISSUE, XFER, DONE. Encoding is free.
- IDLE: req_k = rd_k | wr_k. If one port requests, grant it. If both request, grant the port not equal to last. last resets to 1, so port 0 wins the first tie. On grant: latch sd_lba <= lba_k; set sd_rd <= rd_k and sd_wr <= wr_k & ~rd_k (rd wins if both are set); set grant_k; update last; go to ISSUE.
- ISSUE: hold sd_rd/sd_wr. On sd_ack = 1: clear sd_rd/sd_wr and go to XFER.
- XFER: byte traffic is routed combinationally. buff_wr_k = sd_buff_wr & grant_k. sd_buff_din = granted buff_din. On sd_ack = 0: go to DONE.
- DONE: done_k = 1 for exactly one cycle, grant cleared in the same cycle, then IDLE. The requester drops rd/wr on the cycle after done. A request still high in IDLE is treated as a new transaction.
- Requests that deassert in ISSUE are ignored; the transaction completes normally.
- Only sd_lba, sd_rd, sd_wr, grant, done and err are registered. Buffer routing is combinational.

## Timing
- Reset values: sd_rd = sd_wr = 0, sd_lba = 0, grant_* = 0, done_* = err_* = 0, state = IDLE, last = 1, timeout counter = 0.
- Request high at edge N in IDLE -> grant, sd_rd/sd_wr, sd_lba valid after edge N.
- sd_ack rise sampled at edge M -> sd_rd/sd_wr low after edge M.
- sd_ack fall sampled at edge F -> done high for the cycle after F+1 (edge F enters DONE; DONE outputs the pulse). Next grant is possible at edge F+2.
- Minimum back-to-back gap: one IDLE cycle between transactions.
- Reset asserted mid-transaction: all outputs go to reset values immediately. No done pulse is issued. mist_io may finish its transfer into an ungranted void, because buff_wr_* are gated low.
- sd_ack high while in IDLE (stale): ignored.

## Configuration
- SDARB_TIMEOUT_EN defined:
  - A 24-bit counter clears on entry to ISSUE and increments each ISSUE cycle.
  - When it reaches TIMEOUT_CYCLES-1 without sd_ack: sd_rd/sd_wr drop, the state goes to DONE, and err_k pulses with done_k.
  - The timeout is not applied in XFER.
- SDARB_TIMEOUT_EN undefined: no counter. ISSUE waits indefinitely. err_* are tied to 0.

## Test plan
- Single read, port 0, lba_0 = 32'h0000_1234: sd_rd = 1 and sd_lba = 32'h1234 one cycle after request; ack high for 512 buff_wr strobes; buff_wr_0 sees 512 strobes and buff_wr_1 none; done_0 pulses once, 2 cycles after ack falls.
- Simultaneous rd_0 and wr_1 from reset: port 0 granted first, then port 1. sd_wr = 1 with lba_1 on the second transaction. sd_buff_din equals buff_din_1 during XFER.
- Both ports hold continuous requests for 4 transactions: grant order is 0, 1, 0, 1. grant is never two-hot.
- rd_0 = wr_0 = 1: sd_rd = 1 and sd_wr = 0.
- With SDARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, sd_ack held low: sd_rd drops after 16 ISSUE cycles; done_1 and err_1 pulse together; a subsequent port 0 request is serviced normally.
- Reset pulse during XFER: sd_rd, grant and done are immediately 0 and no done pulse occurs. After reset release, a pending request on rd_1 is granted on the first IDLE edge.
